// File: rtl/bram_resp_adapter.sv
// Valid/ready front end for a BRAM port: issues requests straight to the BRAM,
// tracks reads through an L-stage issue pipeline and queues their data in a response FIFO.
module bram_resp_adapter #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int WE_WIDTH   = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WE_WIDTH-1:0]   req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  bram_en,
  output logic [WE_WIDTH-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data
);

  localparam int L  = PIPELINED + 1;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 2;

  logic [L:1]            rd_vld_p;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         sum;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
  logic                  accept;
  logic                  rd_accept;
  logic                  enq;
  logic                  deq;

  // Every outstanding read already owns a FIFO slot, so the FIFO can never overflow.
  // Only registered counts feed req_ready; a same-cycle dequeue does not help.
  assign sum       = inflight + occ;
  assign req_ready = !RST && (sum < CW'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && (req_we == '0);

  assign bram_en   = accept;
  assign bram_we   = accept ? req_we : '0;
  assign bram_addr = req_addr;
  assign bram_di   = req_data;

  assign enq        = rd_vld_p[L];
  assign deq        = resp_ready && (occ != '0);
  assign resp_valid = (occ != '0);
  assign resp_data  = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_vld_p <= '0;
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      // issue pipeline: stage L coincides with the read's data on bram_do
      rd_vld_p[1] <= rd_accept;
      for (int i = 2; i <= L; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
      end
      inflight <= inflight + CW'(rd_accept) - CW'(enq);
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // response storage is deliberately left unreset
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= bram_do;
  end

endmodule

// File: doc/bram_resp_adapter.md
BRAM_RESP_ADAPTER -- requirements
Module: bram_resp_adapter

Interface
REQ-001 SHALL have parameter PIPELINED, default 0: BRAM read latency is 1 cycle when 0 and 2 cycles when 1.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: data width, equal to WE_WIDTH*8.
REQ-004 SHALL have parameter WE_WIDTH, default 1: number of byte enables.
REQ-005 SHALL have parameter RESP_DEPTH, default 4: response FIFO depth; power of two, 2..16.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, 1 bit: request offered.
REQ-009 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-010 SHALL have port req_we, input, WE_WIDTH bits: byte enables; all zero means read.
REQ-011 SHALL have port req_addr, input, ADDR_WIDTH bits: request address.
REQ-012 SHALL have port req_data, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port bram_en, output, 1 bit: BRAM enable.
REQ-014 SHALL have port bram_we, output, WE_WIDTH bits: BRAM byte enables.
REQ-015 SHALL have port bram_addr, output, ADDR_WIDTH bits: BRAM address.
REQ-016 SHALL have port bram_di, output, DATA_WIDTH bits: BRAM write data.
REQ-017 SHALL have port bram_do, input, DATA_WIDTH bits: BRAM read data.
REQ-018 SHALL have port resp_valid, output, 1 bit: response FIFO not empty.
REQ-019 SHALL have port resp_ready, input, 1 bit: consumer takes the response.
REQ-020 SHALL have port resp_data, output, DATA_WIDTH bits: head-of-FIFO read data.

Function
REQ-021 SHALL drive the BRAM ports combinationally from the request on acceptance: bram_en=1, bram_we=req_we, bram_addr=req_addr, bram_di=req_data; when not accepting, bram_en=0 and bram_we=0.
REQ-022 SHALL track each accepted read in an issue pipeline of L=PIPELINED+1 stages; the stage-L flag marks the cycle in which bram_do holds that read's data, and that bram_do value SHALL be written into the response FIFO.
REQ-023 SHALL not enter writes (req_we nonzero) into the issue pipeline, and SHALL produce no response for them.
REQ-024 SHALL keep inflight, the count of reads in the issue pipeline (0..L), and occ, the FIFO occupancy (0..RESP_DEPTH).
REQ-025 SHALL drive req_ready = (inflight + occ < RESP_DEPTH); the sum is evaluated at width clog2(RESP_DEPTH)+2 so it cannot wrap.
REQ-026 SHALL drive req_ready from registered state only; a dequeue in the same cycle SHALL NOT raise req_ready, so there is no combinational path from resp_ready to req_ready.
REQ-027 SHALL gate acceptance of writes by req_ready as well, keeping BRAM request ordering strict.
REQ-028 SHALL implement the FIFO with wrapping read and write pointers of clog2(RESP_DEPTH) bits and a separate occ counter.
REQ-029 SHALL keep occ unchanged on a cycle with simultaneous enqueue and dequeue.
REQ-030 SHALL, with the FIFO empty and a response arriving, show resp_valid one cycle after data capture; there is no bypass.
REQ-031 SHALL drive resp_data from the head entry and hold it stable while resp_valid=1 and resp_ready=0.
REQ-032 SHALL never drop a response and never overflow; this is guaranteed by REQ-025.
REQ-033 SHALL treat dequeue with resp_valid=0 as a no-op.
REQ-034 SHALL give read-to-resp_valid latency L+1 cycles after acceptance when no backpressure is present.
REQ-035 SHALL deliver responses strictly in request order.

Reset
REQ-036 SHALL, while RST=1 (asynchronously), clear inflight, occ, the FIFO pointers and all issue-pipeline flags.
REQ-037 SHALL hold resp_valid=0, req_ready=0 and bram_en=0 during reset.
REQ-038 SHALL discard reads in flight at reset; their data is never enqueued.
REQ-039 SHALL leave FIFO data storage unreset.
REQ-040 SHALL raise req_ready in the first cycle after RST deasserts.

Verification
REQ-041 Scenario: PIPELINED=0; write addr 3, we=all-ones, data 0xA5; then read addr 3 -> resp_data=0xA5, resp_valid 2 cycles after read acceptance; the write produces no response.
REQ-042 Scenario: PIPELINED=1, RESP_DEPTH=4, resp_ready=0, back-to-back reads addr 0..7 -> exactly 4 accepted, req_ready low thereafter, occ=4; release resp_ready -> data for addr 0..3 in order, then the remaining 4 accepted.
REQ-043 Scenario: FIFO full, resp_ready=1 and req_valid=1 in the same cycle -> dequeue occurs, req_ready stays 0 that cycle and rises the next.
REQ-044 Scenario: WE_WIDTH=2; write 0x1234, then write 0xABCD with we=2'b01 -> read returns 0x12CD.
REQ-045 Scenario: assert RST with 2 reads in flight and 3 entries queued -> resp_valid=0 immediately; after release, a fresh read returns only its own data.
REQ-046 Scenario: 1000 random reads and writes with random resp_ready -> all responses match the scoreboard, in order, with no overflow.
